// File: rtl/ac_store_buffer_pkg.sv
// Shared types and constants for the AC store buffer.
package ac_store_buffer_pkg;

    localparam int WORD_SIZE     = 24;
    localparam int ADDR_SIZE     = 16;
    localparam int DEFAULT_DEPTH = 4;

    // Write-port handshake state
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // One pending store: target address and the captured AC value
    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
    } entry_t;

endpackage

// File: rtl/ac_store_buffer_store_fifo.sv
// Small synchronous FIFO holding pending stores.
// Exposes the head entry and the entry behind it so the write port can
// issue back-to-back beats. When only one entry is stored and a push
// lands in the same cycle, the "second" entry is the incoming word.
module store_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] second,
    output logic             second_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Status flags come straight from the registered count
    always_comb begin
        full         = (count_q == CNT_W'(DEPTH));
        empty        = (count_q == '0);
        push_ok      = push & ~full;
        pop_ok       = pop & ~empty;
        head         = mem[rd_ptr_q];
        second       = (count_q > CNT_W'(1)) ? mem[rd_ptr_q + PTR_W'(1)] : wdata;
        second_valid = (count_q > CNT_W'(1)) | ((count_q == CNT_W'(1)) & push_ok);
    end

    // Pointer and occupancy update
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/ac_store_buffer.sv
// AC store buffer: captures AC values on store commands at a
// post-incrementing address, queues them, and drains them to data memory
// through a req/ack write handshake.
// Optional completed-write counter enabled by defining STORE_COUNT_EN.
module ac_store_buffer #(
    parameter int WORD_SIZE = ac_store_buffer_pkg::WORD_SIZE,
    parameter int ADDR_SIZE = ac_store_buffer_pkg::ADDR_SIZE,
    parameter int DEPTH     = ac_store_buffer_pkg::DEFAULT_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 store_en,
    input  logic [WORD_SIZE-1:0] ac_in,
    input  logic                 addr_load,
    input  logic [ADDR_SIZE-1:0] addr_in,
    output logic                 mem_wr_req,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_wr_ack,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow
`ifdef STORE_COUNT_EN
    ,
    input  logic                 count_clr,
    output logic [15:0]          store_count
`endif
);

    import ac_store_buffer_pkg::*;

    localparam int ENTRY_W = ADDR_SIZE + WORD_SIZE;

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic [ADDR_SIZE-1:0] maddr_q, maddr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic                 overflow_q, overflow_d;

    logic [ADDR_SIZE-1:0] eff_addr;
    logic                 push;
    logic                 pop;
    logic [ENTRY_W-1:0]   fifo_head;
    logic [ENTRY_W-1:0]   fifo_second;
    logic                 fifo_second_valid;
    logic                 fifo_full;
    logic                 fifo_empty;

    store_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .wdata        ({eff_addr, ac_in}),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .head         (fifo_head),
        .second       (fifo_second),
        .second_valid (fifo_second_valid)
    );

    assign full       = fifo_full;
    assign empty      = fifo_empty;
    assign mem_wr_req = req_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = wdata_q;
    assign overflow   = overflow_q;

    // Store address selection, post-increment, and drop detection
    always_comb begin
        eff_addr   = addr_load ? addr_in : addr_q;
        push       = store_en & ~fifo_full;
        addr_d     = push ? eff_addr + ADDR_SIZE'(1) : eff_addr;
        overflow_d = overflow_q | (store_en & fifo_full);
        pop        = (state_q == REQ) & mem_wr_ack;
    end

    // Next-state logic of the write handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = REQ;
            REQ:     if (mem_wr_ack && !fifo_second_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered write-port outputs: load on a new beat, hold until ack
    always_comb begin
        req_d   = req_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    req_d   = 1'b1;
                    maddr_d = fifo_head[ENTRY_W-1 -: ADDR_SIZE];
                    wdata_d = fifo_head[WORD_SIZE-1:0];
                end
            end
            REQ: begin
                if (mem_wr_ack) begin
                    if (fifo_second_valid) begin
                        maddr_d = fifo_second[ENTRY_W-1 -: ADDR_SIZE];
                        wdata_d = fifo_second[WORD_SIZE-1:0];
                    end else begin
                        req_d = 1'b0;
                    end
                end
            end
            default: req_d = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address register, overflow flag and write-port output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            overflow_q <= 1'b0;
            req_q      <= 1'b0;
            maddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            overflow_q <= overflow_d;
            req_q      <= req_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
        end
    end

`ifdef STORE_COUNT_EN
    logic [15:0] store_count_q, store_count_d;

    // Completed-write counter; clear wins over a same-cycle ack
    always_comb begin
        if (count_clr) begin
            store_count_d = '0;
        end else if (pop) begin
            store_count_d = store_count_q + 16'd1;
        end else begin
            store_count_d = store_count_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_count_q <= '0;
        end else begin
            store_count_q <= store_count_d;
        end
    end

    assign store_count = store_count_q;
`endif

endmodule

// File: tb/tb_ac_store_buffer.sv
// Self-checking bench for ac_store_buffer: directed scenarios plus a
// randomized phase, checked against a queue-based model of the buffer.
module tb_ac_store_buffer;

    import ac_store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        store_en = 1'b0;
    logic [23:0] ac_in = '0;
    logic        addr_load = 1'b0;
    logic [15:0] addr_in = '0;
    logic        mem_wr_req;
    logic [15:0] mem_addr;
    logic [23:0] mem_wdata;
    logic        mem_wr_ack;
    logic        full;
    logic        empty;
    logic        overflow;
`ifdef STORE_COUNT_EN
    logic        count_clr = 1'b0;
    logic [15:0] store_count;
`endif

    always #5 clk = ~clk;

    ac_store_buffer #(
        .WORD_SIZE (24),
        .ADDR_SIZE (16),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .store_en   (store_en),
        .ac_in      (ac_in),
        .addr_load  (addr_load),
        .addr_in    (addr_in),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr_ack (mem_wr_ack),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
`ifdef STORE_COUNT_EN
        ,
        .count_clr  (count_clr),
        .store_count(store_count)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: queue of accepted stores awaiting their memory write
    entry_t      exp_q[$];
    int          n_acc = 0;
    int          n_wr  = 0;
    logic [15:0] m_addr = '0;
    bit          m_ovf = 1'b0;

    // Memory responder controls
    bit ack_en    = 1'b0;
    bit ack_rand  = 1'b0;
    int ack_delay = 2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Memory responder: acks a request after ack_delay cycles, one-cycle pulse
    initial begin
        int wcnt;
        wcnt = 0;
        mem_wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || mem_wr_ack) begin
                mem_wr_ack = 1'b0;
                wcnt = 0;
                if (ack_rand) ack_delay = $urandom_range(0, 3);
            end else if (mem_wr_req && ack_en) begin
                if (wcnt >= ack_delay) mem_wr_ack = 1'b1;
                else wcnt++;
            end
        end
    end

    // Write monitor: compares each completed write with the model, and
    // checks address/data stay stable while a request waits for ack
    initial begin
        logic        prev_req;
        logic        prev_ack;
        logic [15:0] prev_addr;
        logic [23:0] prev_data;
        entry_t      e;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (prev_req && !prev_ack && mem_wr_req) begin
                    check("hold_addr", mem_addr, prev_addr);
                    check("hold_data", mem_wdata, prev_data);
                end
                if (mem_wr_req && mem_wr_ack) begin
                    n_wr++;
                    if (exp_q.size() == 0) begin
                        check("write_expected", mem_addr, {48'h0, ~mem_addr});
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_data", mem_wdata, e.data);
                        $display("write addr=%04h data=%06h", mem_addr, mem_wdata);
                    end
                end
                prev_req  = mem_wr_req;
                prev_ack  = mem_wr_ack;
                prev_addr = mem_addr;
                prev_data = mem_wdata;
            end
        end
    end

    // One clock of stimulus; flags are checked against the model first
    task automatic step(input bit st, input logic [23:0] d, input bit ld, input logic [15:0] a);
        int          cnt;
        logic [15:0] eff;
        entry_t      e;
        cnt = n_acc - n_wr;
        check("full", full, (cnt == DEPTH));
        check("empty", empty, (cnt == 0));
        check("overflow", overflow, m_ovf);
        store_en  = st;
        ac_in     = d;
        addr_load = ld;
        addr_in   = a;
        eff = ld ? a : m_addr;
        if (st && cnt != DEPTH) begin
            e.addr = eff;
            e.data = d;
            exp_q.push_back(e);
            n_acc++;
            m_addr = eff + 16'd1;
        end else begin
            if (st) m_ovf = 1'b1;
            m_addr = eff;
        end
        @(posedge clk);
        #1;
        store_en  = 1'b0;
        addr_load = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            step(1'b0, '0, 1'b0, '0);
            k++;
        end
        check("drain_remaining", exp_q.size(), 0);
        check("empty_after_drain", empty, 1);
        check("req_after_drain", mem_wr_req, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        store_en = 1'b0;
        addr_load = 1'b0;
        #1;
        check("rst_req", mem_wr_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        n_acc = 0;
        n_wr = 0;
        m_addr = '0;
        m_ovf = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        do_reset();

        // Latency: store at edge N gives a request after edge N+1
        ack_en = 1'b0;
        step(1'b1, 24'hABCDEF, 1'b0, '0);
        check("lat_req_edgeN", mem_wr_req, 0);
        step(1'b0, '0, 1'b0, '0);
        check("lat_req_edgeN1", mem_wr_req, 1);
        check("lat_addr", mem_addr, 16'h0000);
        check("lat_data", mem_wdata, 24'hABCDEF);
        ack_en = 1'b1;
        ack_delay = 2;
        drain();

        // Three consecutive stores from base 0x0100
        step(1'b0, '0, 1'b1, 16'h0100);
        step(1'b1, 24'h00000A, 1'b0, '0);
        step(1'b1, 24'h00000B, 1'b0, '0);
        step(1'b1, 24'h00000C, 1'b0, '0);
        drain();

        // Fill without acks: 5th store dropped, overflow set
        ack_en = 1'b0;
        step(1'b0, '0, 1'b1, 16'h0300);
        for (int i = 0; i < 4; i++) step(1'b1, 24'h000011 + 24'(i), 1'b0, '0);
        check("full_after_4", full, 1);
        step(1'b1, 24'h000015, 1'b0, '0);
        check("overflow_after_drop", overflow, 1);
        check("full_held", full, 1);
        ack_en = 1'b1;
        drain();
        check("drained_four", n_wr - 3 - 1, 4);
        step(1'b1, 24'h000077, 1'b0, '0);   // lands at base+4
        drain();

        // Address wrap
        step(1'b0, '0, 1'b1, 16'hFFFF);
        step(1'b1, 24'h0000F1, 1'b0, '0);
        step(1'b1, 24'h0000F2, 1'b0, '0);
        drain();

        // Same-cycle load and store
        step(1'b1, 24'h123456, 1'b1, 16'h0200);
        step(1'b1, 24'h654321, 1'b0, '0);
        drain();

        // Randomized traffic with random ack latency and stalls
        ack_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) ack_en = ($urandom_range(0, 3) != 0);
            step(1'($urandom_range(0, 1)), 24'($urandom), ($urandom_range(0, 7) == 0), 16'($urandom));
        end
        ack_en = 1'b1;
        drain();
        ack_rand = 1'b0;
        ack_delay = 2;

        // Reset in the middle of a handshake with entries queued
        ack_en = 1'b0;
        step(1'b1, 24'h0000D1, 1'b0, '0);
        step(1'b1, 24'h0000D2, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        check("pre_rst_req", mem_wr_req, 1);
        check("pre_rst_overflow", overflow, m_ovf);
        rst = 1'b1;
        #1;
        check("midrst_req", mem_wr_req, 0);
        check("midrst_empty", empty, 1);
        check("midrst_overflow", overflow, 0);
        check("midrst_full", full, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        n_acc = 0;
        n_wr = 0;
        m_addr = '0;
        m_ovf = 1'b0;
        ack_en = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, '0);
        check("post_rst_writes", n_wr, 0);

`ifdef STORE_COUNT_EN
        // Completed-write counter and its clear
        do_reset();
        check("cnt_reset", store_count, 0);
        step(1'b1, 24'h000001, 1'b0, '0);
        step(1'b1, 24'h000002, 1'b0, '0);
        step(1'b1, 24'h000003, 1'b0, '0);
        drain();
        check("cnt_three", store_count, n_wr);
        step(1'b1, 24'h000004, 1'b0, '0);
        k = 0;
        while (!mem_wr_ack && k < 20) begin
            step(1'b0, '0, 1'b0, '0);
            k++;
        end
        check("cnt_ack_seen", mem_wr_ack, 1);
        count_clr = 1'b1;
        step(1'b0, '0, 1'b0, '0);
        count_clr = 1'b0;
        check("cnt_clr_priority", store_count, 0);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ac_store_buffer.md
Name: ac_store_buffer

Overview:
- Read-side counterpart of the accumulator register: captures AC values on a store command and writes them to data memory.
- Holds a post-incrementing store address register, so result matrix elements land at consecutive addresses.
- Buffers pending stores in a small FIFO, so the control unit never stalls on a slow memory.
- Drains the FIFO through a req/ack write handshake; sits between the AC register, the control unit and the data-memory port.

Parameters:
- WORD_SIZE, 24, data width; matches the AC register.
- ADDR_SIZE, 16, memory address width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- store_en  input  1  enqueue request: store ac_in at the current address.
- ac_in  input  WORD_SIZE  AC register output.
- addr_load  input  1  load the address register from addr_in.
- addr_in  input  ADDR_SIZE  new base address.
- mem_wr_req  output  1  write request to memory.
- mem_addr  output  ADDR_SIZE  write address.
- mem_wdata  output  WORD_SIZE  write data.
- mem_wr_ack  input  1  memory accepted the write (single-cycle pulse).
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- overflow  output  1  sticky flag: a store was dropped.

Behaviour:
- Reset (async, immediate): FIFO cleared, addr_reg=0, FSM=IDLE, mem_wr_req=0, mem_addr=0, mem_wdata=0, full=0, empty=1, overflow=0.
- Reset mid-handshake: the request is abandoned and queued entries are lost.
- Address register:
  - addr_load: addr_reg <= addr_in.
  - Accepted store: addr_reg <= addr_reg+1, modulo 2^ADDR_SIZE; 0xFFFF wraps to 0x0000.
  - Both in the same cycle: the entry uses addr_in and addr_reg <= addr_in+1.
- Enqueue: when store_en=1 and full=0, push {address, ac_in} at the edge.
- full and empty are derived from the count registered before the edge.
- store_en while full: entry dropped, addr_reg unchanged, overflow <= 1 (held until rst).
- A same-cycle pop does not rescue a store_en issued while full.
- FSM states IDLE and REQ:
  - IDLE: if FIFO not empty, go to REQ. mem_wr_req, mem_addr and mem_wdata are registered from the FIFO head.
  - REQ: mem_wr_req=1; mem_addr and mem_wdata held stable until ack.
  - REQ, mem_wr_ack=1: pop the head. If another entry remains, stay in REQ and present the next head on the following cycle (back-to-back beats); otherwise go to IDLE and set mem_wr_req=0.
- mem_wr_ack in IDLE is ignored.
- Latency: store_en at edge N into an empty, idle buffer gives mem_wr_req=1 in the cycle after edge N+1.
- Simultaneous push and pop: count unchanged; both take effect.
- Order: entries are written to memory in FIFO order; none are reordered or merged.

Optional Feature:
- Macro: STORE_COUNT_EN.
- Defined:
  - Adds output store_count[15:0], counting completed writes (acks accepted in REQ).
  - Reset to 0; wraps at 0xFFFF→0.
  - Adds input count_clr, which zeroes the count synchronously and has priority over a same-cycle increment.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package holds:
  - WORD_SIZE and ADDR_SIZE constants.
  - FSM state typedef (IDLE, REQ).
  - Entry struct type {addr, data}.
- One sub-module, store_fifo:
  - Synchronous FIFO, DEPTH entries, write pointer, read pointer and count.
  - Outputs full, empty and head.
- The top level holds addr_reg, the FSM and the overflow flag.

Test Plan:
- Reset, then addr_load with addr_in=0x0100, then three consecutive store_en with ac_in=0x00000A, 0x00000B, 0x00000C, ack after 2 cycles each → memory sees writes (0x0100,0x00000A), (0x0101,0x00000B), (0x0102,0x00000C) in order; empty=1 at end.
- Hold mem_wr_ack=0 and issue 5 stores → full=1 after the 4th. The 5th is dropped, overflow=1, and addr_reg stays at base+4. Releasing ack drains exactly 4 writes.
- addr_load with addr_in=0xFFFF, then 2 stores → addresses 0xFFFF then 0x0000.
- Same-cycle addr_load (addr_in=0x0200) and store_en (ac_in=0x123456) → write to 0x0200; the next store goes to 0x0201.
- Assert rst while mem_wr_req=1 with 2 entries queued → mem_wr_req=0 immediately, empty=1, overflow=0; no further writes after reset is released.
- With STORE_COUNT_EN defined, complete 3 writes → store_count=3. count_clr in the same cycle as an ack → store_count=0.
